mio_bus_arbiter: RTL and testbench
==================================

# mio_bus_arbiter

Two-master arbiter in front of the MIO bus decoder: shares the single CPU-side bus port (address, write data, write strobe, read data) between the CPU and a second bus master (life-game engine / DMA sequencer). Grants one transaction at a time with a request/ack handshake, stretches the access phase for synchronous-read peripherals, and alternates priority so that neither master starves. Sits between the masters and the decoder's `addr_bus`, `Cpu_data2bus`, `mem_w` and `Cpu_data4bus` ports.

## Interface
- `RD_LAT`, 1, extra access cycles before read data is valid (0..3; block RAM needs 1)
- `MAX_BURST`, 4, max consecutive locked m1 grants while m0 waits (1..15)
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: reset, synchronous, active-low
- `m0_req` / `m1_req` in 1: transaction request; m0 = CPU, m1 = second master
- `m0_we` / `m1_we` in 1: 1 = write, 0 = read
- `m0_addr` / `m1_addr` in 32: byte address
- `m0_wdata` / `m1_wdata` in 32: write data
- `m1_lock` in 1: m1 requests to keep the bus for its next transaction (burst)
- `m0_ack` / `m1_ack` out 1: one-cycle completion pulse
- `m0_rdata` / `m1_rdata` out 32: read data, valid during ack
- `cpu_wait` out 1: stall to CPU; high while `m0_req` is high and no `m0_ack`
- `bus_addr` out 32, `bus_wdata` out 32, `bus_mem_w` out 1: to decoder
- `bus_rdata` in 32: from decoder (`Cpu_data4bus`)
- `gnt` out 2: one-hot current owner (bit0 = m0, bit1 = m1), 0 when idle

## Operation
- FSM states: IDLE, ADDR, WAIT, ACK.
- IDLE: no request -> stay. Single request -> ADDR, owner latched. Both requesting -> winner is the master not served last (`last` register, resets to m1, so m0 wins first); burst override below.
- ADDR (1 cycle): bus driven from owner's inputs; `bus_mem_w` = owner `we`. RD_LAT=0 -> ACK, else -> WAIT.
- WAIT (RD_LAT cycles, down-counter): bus still driven, `bus_mem_w`=0; last cycle -> ACK.
- `bus_rdata` captured into an rdata register on the last driven cycle (ADDR if RD_LAT=0, final WAIT otherwise).
- ACK (1 cycle): owner ack=1, owner rdata = captured value, bus outputs 0, `last` <= owner -> IDLE.
- Masters hold req/we/addr/wdata stable from req rise until ack; after ack, req may be dropped or held for a new transaction (re-arbitrated in IDLE).
- Req dropped before grant: withdrawn, no transaction. Req dropped after grant: transaction completes, ack still pulses.
- Writes: rdata register still loaded, contents don't-care.
- Non-owner rdata outputs are 0.
- `m0_addr` passed unmodified; decoder does region decode.

## Timing
- Reset (rst=0 at edge): state IDLE, `gnt`=0, all acks 0, rdata 0, bus outputs 0, `last`=m1, burst count 0; overrides any transaction in flight (no ack issued).
- Latency req-high-in-IDLE to ack: 2+RD_LAT cycles; back-to-back same-master throughput one transaction per 3+RD_LAT cycles.
- `bus_*` outputs and `gnt` are registered/decoded from state; no combinational path from `m*_req` to bus.
- `cpu_wait` is combinational: `m0_req & ~m0_ack`.

## Configuration
- `MIO_ARB_BURST_EN` defined: in IDLE, if `last`=m1, `m1_lock` was high at last m1 ack and burst count < MAX_BURST, m1 wins even when m0 requests; count increments per locked m1 grant, clears on any m0 grant or on an m1 grant without lock. At MAX_BURST with m0 pending, m0 wins.
- Undefined: `m1_lock` ignored, no burst counter; pure alternation.

## Structure
- Package `mio_arb_pkg`: state enum (IDLE/ADDR/WAIT/ACK), master index constants M0/M1, width constants for RD_LAT and burst counters.
- Sub-module `mio_arb_pick`: combinational winner select from reqs, `last`, lock state, burst count; returns one-hot owner.

## Test plan
- m0 read addr 0x0000_0010, RD_LAT=1, bus_rdata=0xDEAD_BEEF -> `m0_ack` 3 cycles after req, `m0_rdata`=0xDEAD_BEEF, `bus_mem_w` never high.
- m1 write 0xD000_0004 data 0x55 -> ADDR cycle shows `bus_addr`=0xD000_0004, `bus_wdata`=0x55, `bus_mem_w`=1 for exactly one cycle; `m1_ack` next-but-one cycle.
- Both request continuously from reset -> grants alternate m0, m1, m0, m1; `cpu_wait` high only during m0's pending cycles.
- With `MIO_ARB_BURST_EN`, MAX_BURST=4, m1_lock held, m0 requesting -> four consecutive m1 transactions then m0 granted; without macro -> strict alternation.
- rst=0 during WAIT of m0 read -> next cycle IDLE, no ack, all bus outputs 0; after release, held m0_req granted normally.
- m1 raises req then drops it while m0 owns the bus -> no m1 grant, no m1 ack.

Source files
------------

// File: rtl/mio_arb_pkg.sv
// Shared types and constants for the MIO bus arbiter.
// Optional feature macro used by this block: MIO_ARB_BURST_EN (m1 locked bursts).
package mio_arb_pkg;

    // Transaction phases: arbitrate, drive address, stretch for read latency, complete.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        ACK  = 2'd3
    } state_t;

    // Bit positions of the two masters in request / grant vectors.
    localparam int M0 = 0;  // CPU
    localparam int M1 = 1;  // second master (life-game engine / DMA sequencer)

    // Read-latency down-counter width (RD_LAT up to 3).
    localparam int LAT_W   = 2;
    // Burst counter width (MAX_BURST up to 15).
    localparam int BURST_W = 4;

endpackage

// File: rtl/mio_arb_pick.sv
// Combinational winner select for the MIO bus arbiter.
// Alternates between the masters when both request; with MIO_ARB_BURST_EN
// defined, a locked m1 may keep the bus for up to MAX_BURST grants.
module mio_arb_pick
    import mio_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic [1:0]         req,
    input  logic               last_m1,
    input  logic               lock,
    input  logic [BURST_W-1:0] burst_cnt,
    output logic [1:0]         win
);

    logic burst_ok;

`ifdef MIO_ARB_BURST_EN
    // m1 keeps the bus only while it was served last, asked to lock, and has budget left.
    assign burst_ok = last_m1 && lock && (burst_cnt < BURST_W'(MAX_BURST));
`else
    assign burst_ok = 1'b0;
    logic unused_burst;
    assign unused_burst = ^{lock, burst_cnt, (MAX_BURST > 15)};
`endif

    // One-hot winner: a lone requester wins, contention goes to the master not served last.
    always_comb begin
        // NOTE: default first so every path assigns win and no latch is inferred.
        win = 2'b00;
        if (req[M0] && req[M1]) begin
            if (burst_ok || !last_m1) win[M1] = 1'b1;
            else                      win[M0] = 1'b1;
        end else begin
            win = req;
        end
    end

endmodule

// File: rtl/mio_bus_arbiter.sv
// Two-master arbiter in front of the MIO bus decoder. One transaction at a
// time: IDLE (arbitrate) -> ADDR -> WAIT x RD_LAT -> ACK (one-cycle pulse).
// Optional macro: MIO_ARB_BURST_EN enables m1_lock bursts capped at MAX_BURST.
module mio_bus_arbiter
    import mio_arb_pkg::*;
#(
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_lock,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        cpu_wait,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_mem_w,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  gnt
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'((RD_LAT == 0) ? 0 : RD_LAT - 1);

    state_t             state, state_nx;
    logic [1:0]         owner;
    logic [1:0]         win;
    logic               last_m1;
    logic               lock_r;
    logic [BURST_W-1:0] burst_cnt;
    logic [LAT_W-1:0]   lat_cnt;
    logic [31:0]        addr_r, wdata_r, rdata_r;
    logic               we_r;
    logic               driving, acking, capture;

    mio_arb_pick #(.MAX_BURST(MAX_BURST)) u_pick (
        .req       ({m1_req, m0_req}),
        .last_m1   (last_m1),
        .lock      (lock_r),
        .burst_cnt (burst_cnt),
        .win       (win)
    );

    // Last driven cycle: ADDR when there is no read latency, otherwise the final WAIT.
    assign capture = ((state == ADDR) && (RD_LAT == 0)) ||
                     ((state == WAIT) && (lat_cnt == '0));

    // Next-state logic for the transaction phases.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (|win) state_nx = ADDR;
            ADDR: state_nx = (RD_LAT == 0) ? ACK : WAIT;
            WAIT: if (lat_cnt == '0) state_nx = ACK;
            ACK:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register plus the owner's latched transaction, latency count and read capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            owner   <= 2'b00;
            last_m1 <= 1'b1;
            lat_cnt <= '0;
            addr_r  <= '0;
            wdata_r <= '0;
            we_r    <= 1'b0;
            rdata_r <= '0;
        end else begin
            // NOTE: non-blocking so every register sees pre-edge values regardless of order.
            state <= state_nx;
            if (capture) rdata_r <= bus_rdata;
            unique case (state)
                IDLE: if (|win) begin
                    owner   <= win;
                    addr_r  <= win[M1] ? m1_addr  : m0_addr;
                    wdata_r <= win[M1] ? m1_wdata : m0_wdata;
                    we_r    <= win[M1] ? m1_we    : m0_we;
                end
                ADDR: lat_cnt <= LAT_LOAD;
                WAIT: lat_cnt <= lat_cnt - 1'b1;
                ACK: begin
                    last_m1 <= owner[M1];
                    owner   <= 2'b00;
                end
                default: ;
            endcase
        end
    end

`ifdef MIO_ARB_BURST_EN
    // Burst bookkeeping: lock sampled at each m1 ack, count of consecutive locked m1 grants.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lock_r    <= 1'b0;
            burst_cnt <= '0;
        end else begin
            if ((state == ACK) && owner[M1]) lock_r <= m1_lock;
            if ((state == IDLE) && (|win)) begin
                if (win[M1] && m1_lock) begin
                    if (burst_cnt < BURST_W'(MAX_BURST)) burst_cnt <= burst_cnt + 1'b1;
                end else begin
                    burst_cnt <= '0;
                end
            end
        end
    end
`else
    assign lock_r    = 1'b0;
    assign burst_cnt = '0;
    logic unused_lock;
    assign unused_lock = m1_lock;
`endif

    // Outputs decoded from registered state only; nothing combinational from m*_req to the bus.
    assign driving   = (state == ADDR) || (state == WAIT);
    assign acking    = (state == ACK);
    assign gnt       = owner;
    assign bus_addr  = driving ? addr_r  : '0;
    assign bus_wdata = driving ? wdata_r : '0;
    assign bus_mem_w = (state == ADDR) && we_r;
    assign m0_ack    = acking && owner[M0];
    assign m1_ack    = acking && owner[M1];
    assign m0_rdata  = m0_ack ? rdata_r : '0;
    assign m1_rdata  = m1_ack ? rdata_r : '0;
    assign cpu_wait  = m0_req && !m0_ack;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Self-checking bench for mio_bus_arbiter: directed scenarios with literal
// expectations, then randomized masters checked every cycle against a
// transaction-level model (owner, cycle offset within the transaction).
module tb_mio_bus_arbiter;

    localparam int RD_LAT    = 1;
    localparam int MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m_req   [2];
    logic        m_we    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic        m1_lock = 1'b0;
    logic [31:0] bus_rdata = '0;

    logic        m0_ack, m1_ack, cpu_wait, bus_mem_w;
    logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;
    logic [1:0]  gnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Transaction-level model state.
    bit          mbusy = 1'b0;
    int          mown  = 0;
    int          moff  = 0;
    int          mlast = 1;
    bit          mlock = 1'b0;
    int          mbcnt = 0;
    logic [31:0] maddr = '0, mwdata = '0, mcap = '0;
    logic        mwe = 1'b0;

    always #5 clk = ~clk;

    mio_bus_arbiter #(.RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m_req[0]),
        .m0_we     (m_we[0]),
        .m0_addr   (m_addr[0]),
        .m0_wdata  (m_wdata[0]),
        .m1_req    (m_req[1]),
        .m1_we     (m_we[1]),
        .m1_addr   (m_addr[1]),
        .m1_wdata  (m_wdata[1]),
        .m1_lock   (m1_lock),
        .m0_ack    (m0_ack),
        .m1_ack    (m1_ack),
        .m0_rdata  (m0_rdata),
        .m1_rdata  (m1_rdata),
        .cpu_wait  (cpu_wait),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_mem_w (bus_mem_w),
        .bus_rdata (bus_rdata),
        .gnt       (gnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic we, input logic [31:0] a, input logic [31:0] d);
        m_req[m]   = 1'b1;
        m_we[m]    = we;
        m_addr[m]  = a;
        m_wdata[m] = d;
    endtask

    task automatic reset_dut();
        tick();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Model update at each rising edge: a transaction occupies offsets
    // 0..RD_LAT (bus driven) and RD_LAT+1 (ack); arbitration happens on idle cycles.
    task automatic model_step();
        int w;
        w = -1;
        if (!rst) begin
            mbusy = 1'b0; mown = 0; moff = 0; mlast = 1; mlock = 1'b0; mbcnt = 0;
        end else if (mbusy) begin
            if (moff == RD_LAT) mcap = bus_rdata;
            if (moff == RD_LAT + 1) begin
                mlast = mown;
                if (mown == 1) mlock = m1_lock;
                mbusy = 1'b0;
            end else begin
                moff++;
            end
        end else begin
            if (m_req[0] && m_req[1]) begin
                w = (mlast == 1) ? 0 : 1;
`ifdef MIO_ARB_BURST_EN
                if (mlast == 1 && mlock && mbcnt < MAX_BURST) w = 1;
`endif
            end else if (m_req[0]) begin
                w = 0;
            end else if (m_req[1]) begin
                w = 1;
            end
            if (w >= 0) begin
                mbusy = 1'b1; moff = 0; mown = w;
                maddr = m_addr[w]; mwdata = m_wdata[w]; mwe = m_we[w];
`ifdef MIO_ARB_BURST_EN
                if (w == 1 && m1_lock) begin
                    if (mbcnt < MAX_BURST) mbcnt++;
                end else begin
                    mbcnt = 0;
                end
`endif
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare every DUT output against the model once per cycle, mid-cycle.
    initial forever begin
        bit          drv, ackc;
        logic [1:0]  e_gnt;
        @(negedge clk);
        if (cmp_en) begin
            drv   = mbusy && (moff <= RD_LAT);
            ackc  = mbusy && (moff == RD_LAT + 1);
            e_gnt = !mbusy ? 2'b00 : ((mown == 1) ? 2'b10 : 2'b01);
            check("gnt",       32'(gnt),       32'(e_gnt));
            check("bus_addr",  bus_addr,       drv ? maddr  : 32'h0);
            check("bus_wdata", bus_wdata,      drv ? mwdata : 32'h0);
            check("bus_mem_w", 32'(bus_mem_w), 32'(drv && moff == 0 && mwe));
            check("m0_ack",    32'(m0_ack),    32'(ackc && mown == 0));
            check("m1_ack",    32'(m1_ack),    32'(ackc && mown == 1));
            check("m0_rdata",  m0_rdata,       (ackc && mown == 0) ? mcap : 32'h0);
            check("m1_rdata",  m1_rdata,       (ackc && mown == 1) ? mcap : 32'h0);
            check("cpu_wait",  32'(cpu_wait),  32'(m_req[0] && !(ackc && mown == 0)));
        end
    end

    // Record the owner of each new grant over 26 cycles and compare the first six.
    task automatic grant_seq(input string name, input logic [11:0] exp);
        logic [1:0] seq [$];
        logic [1:0] prev;
        prev = 2'b00;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            if (gnt != 2'b00 && prev == 2'b00) seq.push_back(gnt);
            prev = gnt;
        end
        for (int i = 0; i < 6; i++)
            check(name, (i < seq.size()) ? 32'(seq[i]) : 32'h0, 32'(exp[2*i +: 2]));
    endtask

    initial begin
        bit seen_w, seen_g1, seen_a1, seen_a0;
        for (int m = 0; m < 2; m++) begin
            m_req[m] = 1'b0; m_we[m] = 1'b0; m_addr[m] = '0; m_wdata[m] = '0;
        end
        reset_dut();
        cmp_en = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_gnt",    32'(gnt), 32'h0);
        check("rst_addr",   bus_addr, 32'h0);
        check("rst_m0_ack", 32'(m0_ack), 32'h0);
        check("rst_m1_ack", 32'(m1_ack), 32'h0);

        // m0 read of 0x10 with read data 0xDEADBEEF: ack three cycles after request.
        tick();
        set_m(0, 1'b0, 32'h0000_0010, 32'h0);
        bus_rdata = 32'hDEAD_BEEF;
        seen_w = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen_w |= bus_mem_w;
            check("t1_m0_ack", 32'(m0_ack), 32'(i == 3));
            if (i == 3) check("t1_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        end
        check("t1_no_write", 32'(seen_w), 32'h0);
        tick();
        m_req[0] = 1'b0;

        // m1 write: one ADDR cycle with the write strobe, ack the cycle after next.
        tick();
        set_m(1, 1'b1, 32'hD000_0004, 32'h0000_0055);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_mem_w", 32'(bus_mem_w), 32'(i == 1));
            check("t2_m1_ack", 32'(m1_ack), 32'(i == 3));
            if (i == 1) begin
                check("t2_addr",  bus_addr,  32'hD000_0004);
                check("t2_wdata", bus_wdata, 32'h0000_0055);
            end
        end
        tick();
        m_req[1] = 1'b0;

        // Both requesting from reset: strict alternation starting with m0.
        reset_dut();
        set_m(0, 1'b0, 32'h0000_0100, 32'h0);
        set_m(1, 1'b0, 32'hD000_0200, 32'h0);
        grant_seq("t3_alternate", 12'b10_01_10_01_10_01);
        m_req[0] = 1'b0; m_req[1] = 1'b0;

        // Both requesting with m1 locked.
        reset_dut();
        m1_lock = 1'b1;
        set_m(0, 1'b0, 32'h0000_0100, 32'h0);
        set_m(1, 1'b1, 32'hD000_0200, 32'h1);
`ifdef MIO_ARB_BURST_EN
        grant_seq("t4_burst", 12'b01_10_10_10_10_01);
`else
        grant_seq("t4_burst", 12'b10_01_10_01_10_01);
`endif
        m_req[0] = 1'b0; m_req[1] = 1'b0; m1_lock = 1'b0;

        // Reset during WAIT of an m0 read: no ack; held request then served normally.
        reset_dut();
        tick();
        set_m(0, 1'b0, 32'h0000_0020, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5_gnt_wait", 32'(gnt), 32'h1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("t5_gnt_idle", 32'(gnt), 32'h0);
        check("t5_no_ack",   32'(m0_ack), 32'h0);
        check("t5_bus_addr", bus_addr, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("t5_reack", 32'(m0_ack), 32'(i == 3));
        end
        tick();
        m_req[0] = 1'b0;

        // m1 raises then withdraws its request while m0 owns the bus.
        tick();
        set_m(0, 1'b0, 32'h0000_0030, 32'h0);
        tick();
        set_m(1, 1'b0, 32'hD000_0008, 32'h0);
        tick();
        tick();
        m_req[0] = 1'b0; m_req[1] = 1'b0;
        seen_g1 = 1'b0; seen_a1 = 1'b0; seen_a0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen_g1 |= gnt[1];
            seen_a1 |= m1_ack;
            seen_a0 |= m0_ack;
        end
        check("t6_no_m1_gnt", 32'(seen_g1), 32'h0);
        check("t6_no_m1_ack", 32'(seen_a1), 32'h0);
        check("t6_m0_ack",    32'(seen_a0), 32'h1);

        // Randomized masters following the request/ack protocol.
        for (int c = 0; c < 2000; c++) begin
            tick();
            bus_rdata = $urandom;
            m1_lock   = 1'($urandom_range(0, 1));
            for (int m = 0; m < 2; m++) begin
                bit granted, acking;
                granted = mbusy && (mown == m);
                acking  = granted && (moff == RD_LAT + 1);
                if (!m_req[m]) begin
                    if ($urandom_range(0, 3) == 0) set_m(m, 1'($urandom_range(0, 1)), $urandom, $urandom);
                end else if (acking) begin
                    if ($urandom_range(0, 1) == 0) set_m(m, 1'($urandom_range(0, 1)), $urandom, $urandom);
                    else                           m_req[m] = 1'b0;
                end else if (!granted && $urandom_range(0, 15) == 0) begin
                    m_req[m] = 1'b0;
                end
            end
        end
        tick();
        m_req[0] = 1'b0; m_req[1] = 1'b0;
        repeat (8) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
